// File: rtl/cam_sim_pkg.sv
// Shared definitions for the OV7670 camera model: pattern codes, FSM encoding,
// colour-bar table and RGB565 pack/split helpers.
package cam_sim_pkg;

  localparam logic [1:0] PAT_SOLID = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_GRAD  = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBP    = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_HBLANK = 3'd4;
  localparam logic [2:0] ST_VFP    = 3'd5;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam logic [15:0] BAR_RGB [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  function automatic logic [15:0] rgb565_pack(input logic [4:0] r, input logic [5:0] g,
                                              input logic [4:0] b);
    return {r, g, b};
  endfunction

  // Sensor byte order: first byte carries R and G high bits, second G low bits and B.
  function automatic logic [7:0] rgb565_byte(input logic [15:0] c, input logic second);
    rgb565_t p;
    p = c;
    return second ? {p.g[2:0], p.b} : {p.r, p.g[5:3]};
  endfunction

endpackage

// File: rtl/ov7670_sim_src_if.sv
// Camera-side parallel bus: frame/line syncs, byte stream and end-of-frame strobe.
interface ov7670_sim_src_if;
  logic       vsync;
  logic       href;
  logic [7:0] px_data;
  logic       frame_done;

  modport master (output vsync, href, px_data, frame_done);
  modport slave  (input  vsync, href, px_data, frame_done);
endinterface

// File: rtl/ov7670_sim_pattern.sv
// Combinational RGB565 colour of the current pixel for the selected test pattern.
module ov7670_sim_pattern
  import cam_sim_pkg::*;
(
  input  logic [1:0]  pattern,
  input  logic [4:0]  x,
  input  logic [5:0]  y,
  input  logic [2:0]  bar_idx,
  input  logic [15:0] solid_rgb,
  output logic [15:0] rgb
);

  always_comb begin
    rgb = 16'h0000;
    case (pattern)
      PAT_SOLID: rgb = solid_rgb;
      PAT_BARS:  rgb = BAR_RGB[bar_idx];
      PAT_GRAD:  rgb = rgb565_pack(x, y, ~x);
      default:   rgb = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
    endcase
  end

endmodule

// File: rtl/ov7670_sim_src.sv
// OV7670 sensor model: frame/line timing FSM, pixel counters and registered byte stream.
// Optional OV_SIM_FRAME_CNT_EN adds a 16-bit completed-frame counter port.
module ov7670_sim_src
  import cam_sim_pkg::*;
#(
  parameter int H_PIX    = 160,
  parameter int V_LINES  = 120,
  parameter int H_BLANK  = 16,
  parameter int VSYNC_LN = 3,
  parameter int VBP_LN   = 2,
  parameter int VFP_LN   = 2
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         pattern,
  input  logic [15:0]        solid_rgb,
  ov7670_sim_src_if.master   cam
`ifdef OV_SIM_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_cnt
`endif
);

  localparam int L       = 2 * H_PIX + H_BLANK;
  localparam int VS_CYC  = VSYNC_LN * L;
  localparam int VBP_CYC = VBP_LN * L;
  localparam int VFP_CYC = VFP_LN * L - H_BLANK;
  localparam int BAR_W   = H_PIX / 8;
  localparam int CW      = $clog2(VS_CYC + VBP_CYC + VFP_CYC + L + 1);
  localparam int XW      = $clog2(H_PIX);
  localparam int YW      = $clog2(V_LINES + 1);
  localparam int BW      = $clog2(BAR_W + 1);

  logic [2:0]    st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [2:0]    bar, bar_n;
  logic [BW-1:0] barc, barc_n;
  logic [1:0]    pat_q;
  logic [15:0]   solid_q, rgb;
  logic          fd_n;

  always_comb begin
    st_n   = st;
    cnt_n  = cnt + 1'b1;
    x_n    = x;
    y_n    = y;
    bar_n  = bar;
    barc_n = barc;
    case (st)
      ST_IDLE: begin
        cnt_n = '0;
        if (en) begin
          st_n = ST_VSYNC;
          x_n  = '0;
          y_n  = '0;
        end
      end
      ST_VSYNC: if (cnt == CW'(VS_CYC - 1)) begin
        st_n  = ST_VBP;
        cnt_n = '0;
      end
      ST_VBP: if (cnt == CW'(VBP_CYC - 1)) begin
        st_n   = ST_ACTIVE;
        cnt_n  = '0;
        x_n    = '0;
        bar_n  = '0;
        barc_n = '0;
      end
      ST_ACTIVE: if (cnt[0]) begin
        // Second byte of the pixel: advance x and the bar tracker, or close the line.
        if (x == XW'(H_PIX - 1)) begin
          st_n  = ST_HBLANK;
          cnt_n = '0;
        end else begin
          x_n = x + 1'b1;
          if (barc == BW'(BAR_W - 1)) begin
            barc_n = '0;
            bar_n  = bar + 1'b1;
          end else begin
            barc_n = barc + 1'b1;
          end
        end
      end
      ST_HBLANK: if (cnt == CW'(H_BLANK - 1)) begin
        cnt_n  = '0;
        x_n    = '0;
        bar_n  = '0;
        barc_n = '0;
        if (y == YW'(V_LINES - 1)) begin
          st_n = ST_VFP;
        end else begin
          st_n = ST_ACTIVE;
          y_n  = y + 1'b1;
        end
      end
      ST_VFP: if (cnt == CW'(VFP_CYC - 1)) begin
        cnt_n = '0;
        if (en) begin
          st_n = ST_VSYNC;
          y_n  = '0;
        end else begin
          st_n = ST_IDLE;
        end
      end
      default: begin
        st_n  = ST_IDLE;
        cnt_n = '0;
      end
    endcase
  end

  assign fd_n = (st_n == ST_VFP) && (cnt_n == CW'(VFP_CYC - 1));

  ov7670_sim_pattern u_pattern (
    .pattern   (pat_q),
    .x         (5'(x_n)),
    .y         (6'(y_n)),
    .bar_idx   (bar_n),
    .solid_rgb (solid_q),
    .rgb       (rgb)
  );

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      st             <= ST_IDLE;
      cnt            <= '0;
      x              <= '0;
      y              <= '0;
      bar            <= '0;
      barc           <= '0;
      pat_q          <= PAT_SOLID;
      solid_q        <= '0;
      cam.vsync      <= 1'b0;
      cam.href       <= 1'b0;
      cam.px_data    <= 8'h00;
      cam.frame_done <= 1'b0;
    end else begin
      st   <= st_n;
      cnt  <= cnt_n;
      x    <= x_n;
      y    <= y_n;
      bar  <= bar_n;
      barc <= barc_n;
      if (st_n == ST_VSYNC && st != ST_VSYNC) begin
        pat_q   <= pattern;
        solid_q <= solid_rgb;
      end
      cam.vsync      <= (st_n == ST_VSYNC);
      cam.href       <= (st_n == ST_ACTIVE);
      cam.px_data    <= (st_n == ST_ACTIVE) ? rgb565_byte(rgb, cnt_n[0]) : 8'h00;
      cam.frame_done <= fd_n;
    end
  end

`ifdef OV_SIM_FRAME_CNT_EN
  always_ff @(posedge pclk) begin
    if (!rst)      frame_cnt <= '0;
    else if (fd_n) frame_cnt <= frame_cnt + 1'b1;
  end
`endif

endmodule
